// File: rtl/av_config_i2c_pkg.sv
// Shared types and constants for the audio/video configuration I2C target.
// The FSM state encoding is exported so the top can expose it on a debug port.
package av_config_i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } i2c_state_e;

  localparam logic       I2C_RW_WRITE = 1'b0;
  localparam logic       I2C_RW_READ  = 1'b1;
  localparam logic [7:0] READ_FILL    = 8'hFF;

endpackage

// File: rtl/i2c_bus_sampler.sv
// Synchronises the raw SCL/SDA pad inputs and derives single-cycle bus event pulses.
// Every event is computed from synchronised values only.
module i2c_bus_sampler (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_prev;
  logic       sda_prev;
  logic       scl_s;

  // Reset to the idle-bus level so releasing reset never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda       = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  assign start_det = scl_s & scl_prev & sda_prev & ~sda;
  assign stop_det  = scl_s & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/av_config_i2c_responder.sv
// I2C target modelling the codec/decoder register port: 8-bit sub-address pointer with
// auto-increment, byte writes and reads, open-drain SDA pull-down on sda_oe.
module av_config_i2c_responder
  import av_config_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         NUM_REGS    = 16,
  parameter int         HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       reg_wr_valid,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       busy,
  output i2c_state_e dbg_state
);

  localparam int RAW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sampler u_sampler (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda       (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_e       state_q, state_d;
  logic [2:0]       bit_cnt;
  logic [6:0]       shift_q;
  logic [7:0]       pointer;
  logic             rw_q;
  logic             ack_ok_q;
  logic             hold_pending;
  logic [HCW-1:0]   hold_cnt;
  logic [7:0]       regs [NUM_REGS];

  logic [7:0] rx_byte;
  logic       last_bit;
  logic       addr_match;
  logic       ptr_in_range;
  logic [7:0] read_byte;
  logic       drive_low;

  assign rx_byte      = {shift_q, sda_s};
  assign last_bit     = (bit_cnt == 3'd7);
  assign addr_match   = (rx_byte[7:1] == DEV_ADDR);
  assign ptr_in_range = ({24'd0, pointer} < 32'(NUM_REGS));
  assign read_byte    = ptr_in_range ? regs[pointer[RAW-1:0]] : READ_FILL;
  assign dbg_state    = state_q;

  // Bus events move the FSM on SCL rise; START/STOP always win over a coincident edge.
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = ST_IDLE;
    end else if (start_det) begin
      state_d = ST_ADDR;
    end else if (scl_rise) begin
      case (state_q)
        ST_ADDR:      if (last_bit) state_d = addr_match ? ST_ADDR_ACK : ST_IDLE;
        ST_ADDR_ACK:  state_d = (rw_q == I2C_RW_READ) ? ST_RDATA : ST_SUB;
        ST_SUB:       if (last_bit) state_d = ST_SUB_ACK;
        ST_SUB_ACK:   state_d = ST_WDATA;
        ST_WDATA:     if (last_bit) state_d = ST_WDATA_ACK;
        ST_WDATA_ACK: state_d = ST_WDATA;
        ST_RDATA:     if (last_bit) state_d = ST_RDATA_ACK;
        ST_RDATA_ACK: state_d = sda_s ? ST_IDLE : ST_RDATA;
        default:      state_d = state_q;
      endcase
    end
  end

  // SDA level for the low phase that follows an SCL fall; state is stable while SCL is low.
  always_comb begin
    drive_low = 1'b0;
    case (state_q)
      ST_ADDR_ACK,
      ST_SUB_ACK:   drive_low = 1'b1;
      ST_WDATA_ACK: drive_low = ack_ok_q;
      ST_RDATA:     drive_low = ~read_byte[3'd7 - bit_cnt];
      default:      drive_low = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // reg_wr_valid is a one-cycle pulse with addr/data alongside; there is no backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sda_oe       <= 1'b0;
      reg_wr_valid <= 1'b0;
      reg_wr_addr  <= 8'h00;
      reg_wr_data  <= 8'h00;
      busy         <= 1'b0;
      bit_cnt      <= 3'd0;
      shift_q      <= 7'd0;
      pointer      <= 8'h00;
      rw_q         <= I2C_RW_WRITE;
      ack_ok_q     <= 1'b0;
      hold_pending <= 1'b0;
      hold_cnt     <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      reg_wr_valid <= 1'b0;
      if (start_det || stop_det) begin
        bit_cnt      <= 3'd0;
        hold_pending <= 1'b0;
        sda_oe       <= 1'b0;
        if (stop_det) busy <= 1'b0;
      end else begin
        if (scl_rise) begin
          shift_q <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          case (state_q)
            ST_ADDR: begin
              if (last_bit) begin
                busy <= addr_match;
                rw_q <= sda_s;
              end
            end
            ST_ADDR_ACK,
            ST_SUB_ACK,
            ST_WDATA_ACK: bit_cnt <= 3'd0;
            ST_SUB: begin
              if (last_bit) pointer <= rx_byte;
            end
            ST_WDATA: begin
              if (last_bit) begin
                ack_ok_q <= ptr_in_range;
                pointer  <= pointer + 8'd1;
                if (ptr_in_range) begin
                  regs[pointer[RAW-1:0]] <= rx_byte;
                  reg_wr_valid           <= 1'b1;
                  reg_wr_addr            <= pointer;
                  reg_wr_data            <= rx_byte;
                end
              end
            end
            ST_RDATA_ACK: begin
              pointer <= pointer + 8'd1;
              bit_cnt <= 3'd0;
            end
            default: ;
          endcase
        end
        // Data hold time: sda_oe follows drive_low HOLD_CYCLES clocks after the SCL fall.
        if (scl_fall) begin
          hold_pending <= 1'b1;
          hold_cnt     <= HCW'(HOLD_CYCLES - 1);
        end else if (hold_pending) begin
          if (hold_cnt == '0) begin
            sda_oe       <= drive_low;
            hold_pending <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_av_config_i2c_responder.sv
// Bench for av_config_i2c_responder: bit-banged I2C master with an open-drain SDA model,
// a write-pulse scoreboard, a table of single-byte write/readback vectors and corner sequences.
module tb_av_config_i2c_responder;
  import av_config_i2c_pkg::*;

  localparam logic [6:0] DEV = 7'h1A;
  localparam int         Q   = 8;

  typedef struct {
    logic [6:0] dev;
    logic [7:0] sub;
    logic [7:0] data;
    logic       ack_addr;
    logic       ack_sub;
    logic       ack_data;
    logic [7:0] exp_rd;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m;
  logic       sda_m;
  logic       sda_oe;
  logic       reg_wr_valid;
  logic [7:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       busy;
  i2c_state_e dbg_state;
  wire        sda_bus = sda_m & ~sda_oe;

  int          total  = 0;
  int          passed = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  logic        oe_seen;
  logic        busy_after_addr;
  logic [7:0]  rd_buf[16];
  logic [7:0]  wr_buf[4];
  logic        ack_buf[6];
  vec_t        vecs[7];

  always #10 clk = ~clk;

  av_config_i2c_responder dut (
    .clk          (clk),
    .reset        (reset),
    .scl_in       (scl_m),
    .sda_in       (sda_bus),
    .sda_oe       (sda_oe),
    .reg_wr_valid (reg_wr_valid),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Scoreboard: every write pulse must match the head of exp_q.
  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (reg_wr_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected write: got addr %0h data %0h, required no pulse",
                 reg_wr_addr, reg_wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write pulse", {16'd0, reg_wr_addr, reg_wr_data}, {16'd0, mon_exp});
      end
    end
  end

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; wait_q(1);
    scl_m = 1'b1; wait_q(1);
    sda_m = 1'b0; wait_q(1);
    scl_m = 1'b0; wait_q(1);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; wait_q(1);
    scl_m = 1'b1; wait_q(1);
    sda_m = 1'b1; wait_q(1);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b;    wait_q(1);
    scl_m = 1'b1; wait_q(2);
    scl_m = 1'b0; wait_q(1);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; wait_q(1);
    scl_m = 1'b1; wait_q(1);
    b = sda_bus;  wait_q(1);
    scl_m = 1'b0; wait_q(1);
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic get_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  task automatic wr_frame(input logic [6:0] dev, input logic [7:0] sub, input int n);
    i2c_start;
    put_byte({dev, I2C_RW_WRITE}, ack_buf[0]);
    busy_after_addr = busy;
    put_byte(sub, ack_buf[1]);
    for (int i = 0; i < n; i++) put_byte(wr_buf[i], ack_buf[2+i]);
    i2c_stop;
  endtask

  task automatic rd_frame(input logic [7:0] sub, input int n, input logic do_stop);
    i2c_start;
    put_byte({DEV, I2C_RW_WRITE}, ack_buf[0]);
    put_byte(sub, ack_buf[1]);
    i2c_start;
    put_byte({DEV, I2C_RW_READ}, ack_buf[2]);
    check("rd addr ack", {31'd0, ack_buf[0]}, 32'd1);
    check("rd sub ack", {31'd0, ack_buf[1]}, 32'd1);
    check("rd raddr ack", {31'd0, ack_buf[2]}, 32'd1);
    for (int i = 0; i < n; i++) get_byte(rd_buf[i], (i == n - 1));
    if (do_stop) i2c_stop;
  endtask

  initial begin
    vecs[0] = '{7'h1A, 8'h04, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A};
    vecs[1] = '{7'h1B, 8'h05, 8'h77, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{7'h1A, 8'h00, 8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3};
    vecs[3] = '{7'h1A, 8'h0F, 8'h81, 1'b1, 1'b1, 1'b1, 8'h81};
    vecs[4] = '{7'h1A, 8'h10, 8'h99, 1'b1, 1'b1, 1'b0, 8'hFF};
    vecs[5] = '{7'h1A, 8'hFF, 8'h42, 1'b1, 1'b1, 1'b0, 8'hFF};
    vecs[6] = '{7'h0A, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0, 8'hC3};

    // Clock/reset
    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; oe_seen = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset sda_oe", {31'd0, sda_oe}, 32'd0);
    check("reset wr_valid", {31'd0, reg_wr_valid}, 32'd0);
    check("reset wr_addr", {24'd0, reg_wr_addr}, 32'd0);
    check("reset wr_data", {24'd0, reg_wr_data}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset state", 32'(dbg_state), 32'(ST_IDLE));

    // Table of single-byte writes, each followed by a readback of the same sub-address
    for (int i = 0; i < 7; i++) begin
      oe_seen   = 1'b0;
      wr_buf[0] = vecs[i].data;
      if (vecs[i].ack_data) exp_q.push_back({vecs[i].sub, vecs[i].data});
      wr_frame(vecs[i].dev, vecs[i].sub, 1);
      check($sformatf("vec%0d addr ack", i), {31'd0, ack_buf[0]}, {31'd0, vecs[i].ack_addr});
      check($sformatf("vec%0d sub ack", i), {31'd0, ack_buf[1]}, {31'd0, vecs[i].ack_sub});
      check($sformatf("vec%0d data ack", i), {31'd0, ack_buf[2]}, {31'd0, vecs[i].ack_data});
      check($sformatf("vec%0d busy", i), {31'd0, busy_after_addr}, {31'd0, vecs[i].ack_addr});
      if (!vecs[i].ack_addr) check($sformatf("vec%0d no drive", i), {31'd0, oe_seen}, 32'd0);
      check($sformatf("vec%0d busy after stop", i), {31'd0, busy}, 32'd0);
      rd_frame(vecs[i].sub, 1, 1'b1);
      check($sformatf("vec%0d readback", i), {24'd0, rd_buf[0]}, {24'd0, vecs[i].exp_rd});
    end

    // Burst write across the top of the register file
    wr_buf[0] = 8'h11; wr_buf[1] = 8'h22; wr_buf[2] = 8'h33;
    exp_q.push_back({8'h0E, 8'h11});
    exp_q.push_back({8'h0F, 8'h22});
    wr_frame(DEV, 8'h0E, 3);
    check("burst ack0", {31'd0, ack_buf[2]}, 32'd1);
    check("burst ack1", {31'd0, ack_buf[3]}, 32'd1);
    check("burst ack2 nack", {31'd0, ack_buf[4]}, 32'd0);
    rd_frame(8'h0E, 2, 1'b1);
    check("burst rd 0E", {24'd0, rd_buf[0]}, 32'h11);
    check("burst rd 0F", {24'd0, rd_buf[1]}, 32'h22);

    // Pointer wrap FF -> 00
    wr_buf[0] = 8'h01; wr_buf[1] = 8'h02;
    exp_q.push_back({8'h00, 8'h02});
    wr_frame(DEV, 8'hFF, 2);
    check("wrap ff nack", {31'd0, ack_buf[2]}, 32'd0);
    check("wrap 00 ack", {31'd0, ack_buf[3]}, 32'd1);
    rd_frame(8'h00, 1, 1'b1);
    check("wrap rd 00", {24'd0, rd_buf[0]}, 32'h02);

    // Write-then-read through a repeated START, master NACKs the second byte
    wr_buf[0] = 8'hA5; wr_buf[1] = 8'h3C;
    exp_q.push_back({8'h02, 8'hA5});
    exp_q.push_back({8'h03, 8'h3C});
    wr_frame(DEV, 8'h02, 2);
    rd_frame(8'h02, 2, 1'b0);
    check("sr rd 02", {24'd0, rd_buf[0]}, 32'hA5);
    check("sr rd 03", {24'd0, rd_buf[1]}, 32'h3C);
    check("nack release", {31'd0, sda_oe}, 32'd0);
    check("nack state", 32'(dbg_state), 32'(ST_IDLE));
    check("nack busy held", {31'd0, busy}, 32'd1);
    i2c_stop;
    check("stop busy clear", {31'd0, busy}, 32'd0);

    // STOP after three data bits discards the partial byte
    i2c_start;
    put_byte({DEV, I2C_RW_WRITE}, ack_buf[0]);
    put_byte(8'h00, ack_buf[1]);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
    i2c_stop;
    check("abort state", 32'(dbg_state), 32'(ST_IDLE));
    check("abort sda_oe", {31'd0, sda_oe}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    wr_buf[0] = 8'h6B;
    exp_q.push_back({8'h00, 8'h6B});
    wr_frame(DEV, 8'h00, 1);
    check("after abort ack", {31'd0, ack_buf[2]}, 32'd1);
    rd_frame(8'h00, 1, 1'b1);
    check("after abort rd", {24'd0, rd_buf[0]}, 32'h6B);

    // Reset while driving bit 7 (0) of reg 0
    i2c_start;
    put_byte({DEV, I2C_RW_WRITE}, ack_buf[0]);
    put_byte(8'h00, ack_buf[1]);
    i2c_start;
    put_byte({DEV, I2C_RW_READ}, ack_buf[2]);
    repeat (4) @(negedge clk);
    check("rdata drive low", {31'd0, sda_oe}, 32'd1);
    #3 reset = 1'b1;
    #1;
    check("async release", {31'd0, sda_oe}, 32'd0);
    check("async state", 32'(dbg_state), 32'(ST_IDLE));
    check("async busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    wait_q(2);
    rd_frame(8'h00, 16, 1'b1);
    for (int i = 0; i < 16; i++)
      check($sformatf("post reset reg%0d", i), {24'd0, rd_buf[i]}, 32'h00);

    wait_q(2);
    check("pending writes", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
